hi_simulate_ng: RTL and testbench

//  Parametrised ISO 14443 tag-emulation front end for the HF FPGA image.
//  - Load-modulates the antenna by tri-stating pwr_oe1/2/4.
//  - Turns the peak-detector ADC into a bitstream via a threshold comparator with hysteresis.
//  - Exchanges bits with the ARM over a fully framed SSP link.
//  - Generalises the fixed fc/32 link: configurable SSP divider, frame length and thresholds,
//    a new direct-load mode, and mode changes applied only at frame boundaries.

---
 rtl/hi_simulate_ng_pkg.sv | 23 ++
 rtl/hi_simulate_ng_ssp_clk_framer.sv | 54 +++++
 rtl/hi_simulate_ng.sv | 103 ++++++++++
 tb/tb_hi_simulate_ng.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hi_simulate_ng_pkg.sv
// Shared mode codes, framer strobe bundle and width helper for the HF tag-emulation front end.
package hi_sim_pkg;

    localparam logic [2:0] MOD_OFF    = 3'b000;
    localparam logic [2:0] MOD_BPSK   = 3'b001;
    localparam logic [2:0] MOD_OOK212 = 3'b010;
    localparam logic [2:0] MOD_DIRECT = 3'b011;
    localparam logic [2:0] MOD_OOK424 = 3'b100;

    typedef struct packed {
        logic rise_en;
        logic fall_en;
        logic wrap;
    } ssp_stb_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/hi_simulate_ng_ssp_clk_framer.sv
// Free-running carrier divider producing ssp_clk, one-cycle edge strobes and the SSP word framing.
module ssp_clk_framer
    import hi_sim_pkg::*;
#(
    parameter int SSP_DIV_LOG2 = 5,
    parameter int FRAME_BITS   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       act_mode_off,
    output logic [2:0] sub_ph,
    output logic       ssp_clk,
    output logic       ssp_frame,
    output ssp_stb_t   stb
);

    localparam int L  = SSP_DIV_LOG2;
    localparam int FW = clog2(FRAME_BITS);
    localparam logic [L-1:0] RISE_PT = {1'b0, {(L-1){1'b1}}};
    localparam logic [L-1:0] FALL_PT = {L{1'b1}};

    logic [6:0]    div_q, div_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          frame_q, frame_d;
    logic          adv;

    always_comb begin
        div_d       = div_q + 7'd1;
        stb.rise_en = (div_q[L-1:0] == RISE_PT);
        stb.fall_en = (div_q[L-1:0] == FALL_PT);
        // With no modulation the frame tracks the rising edge, otherwise the falling edge.
        adv         = act_mode_off ? stb.rise_en : stb.fall_en;
        stb.wrap    = adv && (fcnt_q == {FW{1'b1}});
        fcnt_d      = adv ? fcnt_q + {{(FW-1){1'b0}}, 1'b1} : fcnt_q;
        frame_d     = (fcnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            fcnt_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            fcnt_q  <= fcnt_d;
            frame_q <= frame_d;
        end
    end

    assign sub_ph    = div_q[L:L-2];
    assign ssp_clk   = div_q[L-1];
    assign ssp_frame = frame_q;

endmodule

// File: rtl/hi_simulate_ng.sv
// ISO 14443 tag-emulation front end: hysteresis comparator, framed SSP link and load modulation.
module hi_simulate_ng
    import hi_sim_pkg::*;
#(
    parameter int ADC_W        = 8,
    parameter int HYST_HI      = 224,
    parameter int HYST_LO      = 31,
    parameter int SSP_DIV_LOG2 = 5,
    parameter int FRAME_BITS   = 8
) (
    input  logic             ck_1356meg,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] adc_d,
    output logic             adc_clk,
    input  logic [2:0]       mod_type,
    input  logic             ssp_dout,
    output logic             ssp_clk,
    output logic             ssp_frame,
    output logic             ssp_din,
    output logic             pwr_oe1,
    output logic             pwr_oe2,
    output logic             pwr_oe4,
    output logic             pwr_oe3,
    output logic             pwr_hi,
    output logic             pwr_lo,
    output logic             dbg
);

    localparam logic [ADC_W-1:0] TH_HI = ADC_W'(HYST_HI);
    localparam logic [ADC_W-1:0] TH_LO = ADC_W'(HYST_LO);

    logic [ADC_W-1:0] adc_q, adc_d_nx;
    logic             hyst_q, hyst_d;
    logic             din_q, din_d;
    logic             tx_q, tx_d;
    logic [2:0]       act_q, act_d;
    logic             pwr_q, pwr_d;
    logic [2:0]       sub_ph;
    ssp_stb_t         stb;

    ssp_clk_framer #(
        .SSP_DIV_LOG2 (SSP_DIV_LOG2),
        .FRAME_BITS   (FRAME_BITS)
    ) u_framer (
        .clk          (ck_1356meg),
        .rst_n        (reset_n),
        .act_mode_off (act_q == MOD_OFF),
        .sub_ph       (sub_ph),
        .ssp_clk      (ssp_clk),
        .ssp_frame    (ssp_frame),
        .stb          (stb)
    );

    always_comb begin
        adc_d_nx = adc_d;
        hyst_d   = hyst_q;
        if (adc_q >= TH_HI)      hyst_d = 1'b1;
        else if (adc_q <= TH_LO) hyst_d = 1'b0;

        din_d = stb.rise_en ? hyst_q   : din_q;
        tx_d  = stb.rise_en ? ssp_dout : tx_q;
        // Mode requests only take effect on a frame boundary so a word is never split.
        act_d = stb.wrap ? mod_type : act_q;

        // sub_ph = div[L:L-2]
        unique case (act_q)
            MOD_BPSK:   pwr_d = tx_q ^ sub_ph[0];
            MOD_OOK212: pwr_d = tx_q & sub_ph[2];
            MOD_DIRECT: pwr_d = tx_q;
            MOD_OOK424: pwr_d = tx_q & sub_ph[1];
            default:    pwr_d = 1'b0;
        endcase
    end

    always_ff @(posedge ck_1356meg or negedge reset_n) begin
        if (!reset_n) begin
            adc_q  <= '0;
            hyst_q <= 1'b0;
            din_q  <= 1'b0;
            tx_q   <= 1'b0;
            act_q  <= MOD_OFF;
            pwr_q  <= 1'b0;
        end else begin
            adc_q  <= adc_d_nx;
            hyst_q <= hyst_d;
            din_q  <= din_d;
            tx_q   <= tx_d;
            act_q  <= act_d;
            pwr_q  <= pwr_d;
        end
    end

    assign adc_clk = ck_1356meg;
    assign ssp_din = din_q;
    assign dbg     = hyst_q;
    assign pwr_oe1 = pwr_q;
    assign pwr_oe2 = pwr_q;
    assign pwr_oe4 = pwr_q;
    assign pwr_oe3 = 1'b0;
    assign pwr_hi  = 1'b0;
    assign pwr_lo  = 1'b0;

endmodule

// File: tb/tb_hi_simulate_ng.sv
// Bench for hi_simulate_ng: default instance plus an L=4/16-bit-frame instance, cycle model and directed checks.
module tb_hi_simulate_ng;

    logic       ck = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] adc_d = '0, adc5 = '0;
    logic [2:0] mod_type = '0, mt5 = 3'd3;
    logic       ssp_dout = 1'b0, dout5 = 1'b0;
    logic       adc_clk, ssp_clk, ssp_frame, ssp_din, pwr_oe1, pwr_oe2, pwr_oe4;
    logic       pwr_oe3, pwr_hi, pwr_lo, dbg;
    logic       adc_clk5, ssp_clk5, ssp_frame5, ssp_din5, p1_5, p2_5, p4_5;
    logic       p3_5, phi5, plo5, dbg5;

    int  nvec = 0, nbad = 0, cyc = 0;
    bit  chk_en = 0;
    logic [3:0] pat5 = 4'b1010;

    always #10 ck = ~ck;

    hi_simulate_ng dut (
        .ck_1356meg(ck), .reset_n(reset_n), .adc_d(adc_d), .adc_clk(adc_clk),
        .mod_type(mod_type), .ssp_dout(ssp_dout), .ssp_clk(ssp_clk), .ssp_frame(ssp_frame),
        .ssp_din(ssp_din), .pwr_oe1(pwr_oe1), .pwr_oe2(pwr_oe2), .pwr_oe4(pwr_oe4),
        .pwr_oe3(pwr_oe3), .pwr_hi(pwr_hi), .pwr_lo(pwr_lo), .dbg(dbg));

    hi_simulate_ng #(.SSP_DIV_LOG2(4), .FRAME_BITS(16)) dut5 (
        .ck_1356meg(ck), .reset_n(reset_n), .adc_d(adc5), .adc_clk(adc_clk5),
        .mod_type(mt5), .ssp_dout(dout5), .ssp_clk(ssp_clk5), .ssp_frame(ssp_frame5),
        .ssp_din(ssp_din5), .pwr_oe1(p1_5), .pwr_oe2(p2_5), .pwr_oe4(p4_5),
        .pwr_oe3(p3_5), .pwr_hi(phi5), .pwr_lo(plo5), .dbg(dbg5));

    // Reference model: n counts clock edges since reset, so the divider value is n mod 128.
    typedef struct {
        int n; int adc; int act; int fc;
        bit hyst; bit din; bit tx; bit frame; bit pwr;
    } mstate_t;

    mstate_t m0, m5;

    function automatic mstate_t mnext(mstate_t s, int adc, int mt, bit dout, int L, int fb);
        mstate_t r;
        int d, sub;
        bit rise, fall, adv;
        r = s;
        d = s.n % 128;
        sub = d % (1 << L);
        rise = (sub == (1 << (L - 1)) - 1);
        fall = (sub == (1 << L) - 1);
        adv = (s.act == 0) ? rise : fall;
        case (s.act)
            1: r.pwr = s.tx ^ (((d >> (L - 2)) & 1) == 1);
            2: r.pwr = s.tx & (((d >> L) & 1) == 1);
            3: r.pwr = s.tx;
            4: r.pwr = s.tx & (((d >> (L - 1)) & 1) == 1);
            default: r.pwr = 0;
        endcase
        r.frame = (s.fc == 0);
        if (adv) r.fc = (s.fc + 1) % fb;
        if (adv && s.fc == fb - 1) r.act = mt;
        if (rise) begin r.din = s.hyst; r.tx = dout; end
        if (s.adc >= 224) r.hyst = 1;
        else if (s.adc <= 31) r.hyst = 0;
        r.adc = adc;
        r.n = s.n + 1;
        return r;
    endfunction

    function automatic bit mclk(mstate_t s, int L);
        return (((s.n % 128) >> (L - 1)) & 1) == 1;
    endfunction

    always @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            m0 <= '{default: 0};
            m5 <= '{default: 0};
        end else begin
            m0 <= mnext(m0, int'(adc_d), int'(mod_type), ssp_dout, 5, 8);
            m5 <= mnext(m5, int'(adc5), int'(mt5), dout5, 4, 16);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge ck) begin
        if (chk_en) begin
            chk("ssp_clk",   ssp_clk,   mclk(m0, 5));
            chk("ssp_frame", ssp_frame, m0.frame);
            chk("ssp_din",   ssp_din,   m0.din);
            chk("dbg",       dbg,       m0.hyst);
            chk("pwr_oe124", {pwr_oe1, pwr_oe2, pwr_oe4}, m0.pwr ? 7 : 0);
            chk("pwr_const", {pwr_oe3, pwr_hi, pwr_lo}, 0);
            chk("ssp_clk5",   ssp_clk5,   mclk(m5, 4));
            chk("ssp_frame5", ssp_frame5, m5.frame);
            chk("pwr_oe5",    {p1_5, p2_5, p4_5}, m5.pwr ? 7 : 0);
        end
    end

    task automatic tick();
        @(negedge ck);
        cyc++;
        dout5 = pat5[(cyc / 16) % 4];
    endtask

    function automatic logic sig(input int which);
        case (which)
            0: return ssp_clk;
            1: return pwr_oe1;
            2: return ssp_clk5;
            default: return ssp_frame;
        endcase
    endfunction

    task automatic wait_rise(input int which, output bit ok);
        logic prev;
        ok = 0;
        prev = sig(which);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!prev && sig(which)) begin ok = 1; return; end
            prev = sig(which);
        end
    endtask

    task automatic measure_period(input int which, input string nm, input int exp);
        bit ok;
        int c;
        logic prev;
        wait_rise(which, ok);
        if (!ok) begin chk({nm, "_timeout"}, 0, 1); return; end
        c = 0;
        prev = 1'b1;
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            tick();
            c++;
            if (!prev && sig(which)) ok = 1;
            prev = sig(which);
        end
        if (!ok) chk({nm, "_timeout"}, 0, 1);
        else chk(nm, c, exp);
    endtask

    task automatic measure_high(input int which, input string nm, input int exp);
        bit ok;
        int c;
        wait_rise(which, ok);
        if (!ok) begin chk({nm, "_timeout"}, 0, 1); return; end
        c = 0;
        while (sig(which) && c < 1000) begin tick(); c++; end
        chk(nm, c, exp);
    endtask

    task automatic measure_toggle(input int which, input string nm, input int exp);
        logic prev;
        int c;
        prev = sig(which);
        c = 0;
        while (sig(which) == prev && c < 1000) begin tick(); c++; end
        prev = sig(which);
        c = 0;
        while (sig(which) == prev && c < 1000) begin tick(); c++; end
        chk(nm, c, exp);
    endtask

    typedef struct { logic [7:0] adc; logic exp_dbg; } cvec_t;
    cvec_t cv[11];

    initial begin
        bit ok;
        cv[0]  = '{8'd240, 1'b1}; cv[1]  = '{8'd100, 1'b1}; cv[2] = '{8'd20,  1'b0};
        cv[3]  = '{8'd100, 1'b0}; cv[4]  = '{8'd230, 1'b1}; cv[5] = '{8'd31,  1'b0};
        cv[6]  = '{8'd223, 1'b0}; cv[7]  = '{8'd224, 1'b1}; cv[8] = '{8'd32,  1'b1};
        cv[9]  = '{8'd0,   1'b0}; cv[10] = '{8'd255, 1'b1};

        // Reset state
        repeat (3) tick();
        chk("rst_pwr",   {pwr_oe1, pwr_oe2, pwr_oe4, pwr_oe3, pwr_hi, pwr_lo}, 0);
        chk("rst_ssp",   {ssp_clk, ssp_frame, ssp_din, dbg}, 0);
        chk("rst_dut5",  {ssp_clk5, ssp_frame5, ssp_din5, dbg5, p1_5}, 0);
        chk("adc_clk_lo", adc_clk, 0);
        #12 chk("adc_clk_hi", adc_clk, 1);
        tick();
        reset_n = 1'b1;
        chk_en = 1;

        // Defaults: ssp_clk 32 clocks, frame high one ssp_clk period in eight
        measure_period(0, "ssp_clk_period", 32);
        measure_period(3, "frame_period", 256);
        measure_high(3, "frame_high", 32);
        measure_period(2, "ssp_clk5_period", 16);

        // Comparator thresholds and 2-clock latency
        foreach (cv[i]) begin
            adc_d = cv[i].adc;
            tick(); tick();
            chk($sformatf("dbg_vec%0d", i), dbg, cv[i].exp_dbg);
        end

        // BPSK, then inverted data
        mod_type = 3'd1; ssp_dout = 1'b1;
        repeat (600) tick();
        measure_toggle(1, "bpsk_toggle", 8);
        ssp_dout = 1'b0;
        repeat (300) tick();
        measure_toggle(1, "bpsk_toggle_d0", 8);

        // OOK212 -> OOK424 requested mid-frame
        mod_type = 3'd2; ssp_dout = 1'b1;
        repeat (600) tick();
        measure_period(1, "ook212_period", 64);
        wait_rise(3, ok);
        while (ssp_frame && ok) tick();
        mod_type = 3'd4;
        measure_period(1, "ook_deferred_period", 64);
        repeat (300) tick();
        measure_period(1, "ook424_period", 32);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            adc_d = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'd250 : 8'd5)
                                                 : 8'($urandom_range(0, 255));
            adc5 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 63) == 0) mod_type = 3'($urandom_range(0, 7));
            ssp_dout = 1'($urandom_range(0, 1));
            tick();
        end

        // Asynchronous reset while modulating
        mod_type = 3'd3; ssp_dout = 1'b1;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick();
            if (pwr_oe1) ok = 1;
        end
        chk("pwr_hi_before_reset", pwr_oe1, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_pwr", {pwr_oe1, pwr_oe2, pwr_oe4}, 0);
        chk("async_rst_frame", ssp_frame, 0);
        tick();
        #3 reset_n = 1'b1;
        repeat (400) tick();
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
